// File: rtl/pulse_scan_pkg.sv
// Shared state encoding and constants for the round-robin pulse scanner.
// Constants are kept at a fixed maximum width; users slice them to N_BITS.
package pulse_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_LOW,
        MEASURE,
        STORE,
        NEXT
    } state_e;

    localparam int MAX_N_BITS = 32;
    localparam logic [MAX_N_BITS-1:0] CNT_SAT  = '1;
    localparam logic [MAX_N_BITS-1:0] MIN_INIT = '1;

endpackage

// File: rtl/pulse_scan_ctrl_if.sv
// Host-side bundle of the pulse scanner: scan control, pulse inputs, read port and status.
// master = host/stimulus side, slave = the scanner.
interface pulse_scan_ctrl_if #(
    parameter int N_CH     = 4,
    parameter int N_BITS   = 8,
    parameter int WIN_BITS = 16
);
    localparam int CH_W = $clog2(N_CH);

    logic                enable;
    logic [WIN_BITS-1:0] window_len;
    logic [N_CH-1:0]     pulse_in;
    logic [CH_W-1:0]     rd_ch;
    logic [N_BITS-1:0]   rd_max;
    logic [N_BITS-1:0]   rd_min;
    logic                rd_valid;
    logic [CH_W-1:0]     cur_ch;
    logic                busy;
    logic                sweep_done;

    modport master (
        output enable, window_len, pulse_in, rd_ch,
        input  rd_max, rd_min, rd_valid, cur_ch, busy, sweep_done
    );

    modport slave (
        input  enable, window_len, pulse_in, rd_ch,
        output rd_max, rd_min, rd_valid, cur_ch, busy, sweep_done
    );

endinterface

// File: rtl/pulse_len_core.sv
// Single-channel pulse-length datapath: saturating length counter plus working max/min.
// Build option PULSE_SCAN_MIN_EN adds the working minimum and its output port.
module pulse_len_core
    import pulse_scan_pkg::*;
#(
    parameter int N_BITS = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              en,
    input  logic              pulse,
    output logic [N_BITS-1:0] work_max,
`ifdef PULSE_SCAN_MIN_EN
    output logic [N_BITS-1:0] work_min,
`endif
    output logic              got_pulse
);
    localparam logic [N_BITS-1:0] SAT = CNT_SAT[N_BITS-1:0];

    logic              in_pulse_q, in_pulse_d;
    logic [N_BITS-1:0] cnt_q, cnt_d;
    logic [N_BITS-1:0] max_q, max_d;
    logic              got_q, got_d;
`ifdef PULSE_SCAN_MIN_EN
    logic [N_BITS-1:0] min_q, min_d;
`endif

    always_comb begin
        in_pulse_d = in_pulse_q;
        cnt_d      = cnt_q;
        max_d      = max_q;
        got_d      = got_q;
`ifdef PULSE_SCAN_MIN_EN
        min_d      = min_q;
`endif
        if (clr) begin
            in_pulse_d = 1'b0;
            cnt_d      = '0;
            max_d      = '0;
            got_d      = 1'b0;
`ifdef PULSE_SCAN_MIN_EN
            min_d      = MIN_INIT[N_BITS-1:0];
`endif
        end else if (en) begin
            if (pulse) begin
                if (!in_pulse_q) begin
                    in_pulse_d = 1'b1;
                    cnt_d      = N_BITS'(1);
                end else if (cnt_q != SAT) begin
                    cnt_d = cnt_q + N_BITS'(1);
                end
            end else if (in_pulse_q) begin
                // Falling edge: the pulse is complete, fold it into the window result.
                in_pulse_d = 1'b0;
                got_d      = 1'b1;
                if (cnt_q > max_q) max_d = cnt_q;
`ifdef PULSE_SCAN_MIN_EN
                if (cnt_q < min_q) min_d = cnt_q;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_pulse_q <= 1'b0;
            cnt_q      <= '0;
            max_q      <= '0;
            got_q      <= 1'b0;
`ifdef PULSE_SCAN_MIN_EN
            min_q      <= MIN_INIT[N_BITS-1:0];
`endif
        end else begin
            in_pulse_q <= in_pulse_d;
            cnt_q      <= cnt_d;
            max_q      <= max_d;
            got_q      <= got_d;
`ifdef PULSE_SCAN_MIN_EN
            min_q      <= min_d;
`endif
        end
    end

    assign work_max  = max_q;
    assign got_pulse = got_q;
`ifdef PULSE_SCAN_MIN_EN
    assign work_min  = min_q;
`endif

endmodule

// File: rtl/pulse_scan_ctrl.sv
// Round-robin pulse-width scanner: one measurement core time-shared over N_CH inputs.
// Define PULSE_SCAN_MIN_EN to include minimum tracking and the min result bank.
module pulse_scan_ctrl
    import pulse_scan_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int N_BITS   = 8,
    parameter int WIN_BITS = 16
) (
    input logic              clk,
    input logic              reset_n,
    pulse_scan_ctrl_if.slave bus
);
    localparam int              CH_W    = $clog2(N_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
    logic [WIN_BITS-1:0] win_q, win_d;
    logic                core_clr, core_en, store;
    logic                sel_pulse, win_last;
    logic [N_BITS-1:0]   work_max;
    logic                got_pulse;
    logic [N_BITS-1:0]   bank_max_q [N_CH];
    logic [N_BITS-1:0]   bank_max_d [N_CH];
    logic [N_CH-1:0]     valid_q, valid_d;
`ifdef PULSE_SCAN_MIN_EN
    logic [N_BITS-1:0]   work_min;
    logic [N_BITS-1:0]   bank_min_q [N_CH];
    logic [N_BITS-1:0]   bank_min_d [N_CH];
`endif

    assign sel_pulse = bus.pulse_in[cur_ch_q];
    assign win_last  = (win_q == WIN_BITS'(1));

    pulse_len_core #(.N_BITS(N_BITS)) u_core (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (core_clr),
        .en        (core_en),
        .pulse     (sel_pulse),
        .work_max  (work_max),
`ifdef PULSE_SCAN_MIN_EN
        .work_min  (work_min),
`endif
        .got_pulse (got_pulse)
    );

    // Dropping enable inside a window abandons it; STORE and NEXT always run to completion.
    always_comb begin
        state_d  = state_q;
        cur_ch_d = cur_ch_q;
        win_d    = win_q;
        core_clr = 1'b0;
        core_en  = 1'b0;
        store    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.enable) state_d = ARM;
            end
            ARM: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else begin
                    win_d    = (bus.window_len == '0) ? WIN_BITS'(1) : bus.window_len;
                    core_clr = 1'b1;
                    state_d  = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (win_last) begin
                    state_d = STORE;
                end else begin
                    win_d = win_q - WIN_BITS'(1);
                    if (!sel_pulse) state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else begin
                    core_en = 1'b1;
                    if (win_last) state_d = STORE;
                    else          win_d   = win_q - WIN_BITS'(1);
                end
            end
            STORE: begin
                store   = 1'b1;
                state_d = NEXT;
            end
            NEXT: begin
                cur_ch_d = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + CH_W'(1);
                state_d  = bus.enable ? ARM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bank_max_d = bank_max_q;
        valid_d    = valid_q;
`ifdef PULSE_SCAN_MIN_EN
        bank_min_d = bank_min_q;
`endif
        if (store && got_pulse) begin
            bank_max_d[cur_ch_q] = work_max;
            valid_d[cur_ch_q]    = 1'b1;
`ifdef PULSE_SCAN_MIN_EN
            bank_min_d[cur_ch_q] = work_min;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cur_ch_q <= '0;
            win_q    <= '0;
            valid_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                bank_max_q[i] <= '0;
`ifdef PULSE_SCAN_MIN_EN
                bank_min_q[i] <= MIN_INIT[N_BITS-1:0];
`endif
            end
        end else begin
            state_q    <= state_d;
            cur_ch_q   <= cur_ch_d;
            win_q      <= win_d;
            valid_q    <= valid_d;
            bank_max_q <= bank_max_d;
`ifdef PULSE_SCAN_MIN_EN
            bank_min_q <= bank_min_d;
`endif
        end
    end

    // Out-of-range read selects return an empty result rather than aliasing a channel.
    always_comb begin
        bus.rd_max   = '0;
        bus.rd_min   = '0;
        bus.rd_valid = 1'b0;
        if (32'(bus.rd_ch) < N_CH) begin
            bus.rd_max   = bank_max_q[bus.rd_ch];
            bus.rd_valid = valid_q[bus.rd_ch];
`ifdef PULSE_SCAN_MIN_EN
            bus.rd_min   = bank_min_q[bus.rd_ch];
`endif
        end
    end

    assign bus.cur_ch     = cur_ch_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.sweep_done = (state_q == NEXT) && (cur_ch_q == LAST_CH);

endmodule

// File: tb/tb_pulse_scan_ctrl.sv
// Self-checking bench for pulse_scan_ctrl: directed table vectors plus random sweeps
// against a run-length reference model; works with or without PULSE_SCAN_MIN_EN.
module tb_pulse_scan_ctrl;
    localparam int N_CH     = 4;
    localparam int N_BITS   = 8;
    localparam int WIN_BITS = 16;
    localparam int CH_W     = $clog2(N_CH);
    localparam int SAT      = (1 << N_BITS) - 1;
    localparam int STIM_LEN = 4096;
`ifdef PULSE_SCAN_MIN_EN
    localparam bit MIN_EN = 1'b1;
`else
    localparam bit MIN_EN = 1'b0;
`endif

    typedef struct {
        int after_sweep;
        int ch;
        int max_len;
        int min_len;
        bit valid;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [N_CH-1:0] stim [STIM_LEN];
    int   exp_max   [N_CH];
    int   exp_min   [N_CH];
    bit   exp_valid [N_CH];
    int   exp_cur;
    vec_t vecs [8];

    pulse_scan_ctrl_if #(.N_CH(N_CH), .N_BITS(N_BITS), .WIN_BITS(WIN_BITS)) bus ();

    pulse_scan_ctrl #(.N_CH(N_CH), .N_BITS(N_BITS), .WIN_BITS(WIN_BITS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            exp_max[c]   = 0;
            exp_min[c]   = SAT;
            exp_valid[c] = 1'b0;
        end
        exp_cur = 0;
    endtask

    // Reference: skip samples until the first low, then take every high run that is
    // closed by a low inside the window; lengths saturate at SAT.
    task automatic model_window(input int c, input int r0, input int le);
        int  t0;
        int  run;
        int  len;
        int  mx;
        int  mn;
        bit  got;
        bit  b;
        t0 = -1; run = 0; mx = 0; mn = SAT; got = 1'b0;
        for (int j = 0; j < le; j++) begin
            b = stim[r0 + j][c];
            if (t0 < 0) begin
                if (!b) t0 = j;
            end else if (b) begin
                run++;
            end else if (run > 0) begin
                len = (run > SAT) ? SAT : run;
                got = 1'b1;
                if (len > mx) mx = len;
                if (len < mn) mn = len;
                run = 0;
            end
        end
        if (got) begin
            exp_max[c]   = mx;
            exp_min[c]   = mn;
            exp_valid[c] = 1'b1;
        end
    endtask

    task automatic check_bank(input string tag);
        for (int c = 0; c < N_CH; c++) begin
            bus.rd_ch = CH_W'(c);
            #1;
            check_output($sformatf("%s rd_max ch%0d", tag, c), int'(bus.rd_max), exp_max[c]);
            check_output($sformatf("%s rd_min ch%0d", tag, c), int'(bus.rd_min), MIN_EN ? exp_min[c] : 0);
            check_output($sformatf("%s rd_valid ch%0d", tag, c), int'(bus.rd_valid), int'(exp_valid[c]));
        end
    endtask

    task automatic check_table(input int sweep_id);
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].after_sweep == sweep_id) begin
                bus.rd_ch = CH_W'(vecs[i].ch);
                #1;
                check_output($sformatf("table%0d max ch%0d", sweep_id, vecs[i].ch), int'(bus.rd_max), vecs[i].max_len);
                check_output($sformatf("table%0d min ch%0d", sweep_id, vecs[i].ch), int'(bus.rd_min),
                             MIN_EN ? vecs[i].min_len : 0);
                check_output($sformatf("table%0d valid ch%0d", sweep_id, vecs[i].ch), int'(bus.rd_valid),
                             int'(vecs[i].valid));
            end
        end
    endtask

    task automatic clear_stim();
        for (int r = 0; r < STIM_LEN; r++) stim[r] = '0;
    endtask

    task automatic fill_random(input int n_edges);
        bit v;
        for (int c = 0; c < N_CH; c++) begin
            v = 1'($urandom_range(0, 1));
            for (int r = 0; r < n_edges && r < STIM_LEN; r++) begin
                if ($urandom_range(0, 3) == 0) v = ~v;
                stim[r][c] = v;
            end
        end
    endtask

    // Mark window-relative samples j0..j0+len-1 high for channel c, i-th channel of the sweep.
    task automatic set_hi(input int c, input int i, input int per, input int j0, input int len);
        for (int k = 0; k < len; k++) stim[2 + i * per + j0 + k][c] = 1'b1;
    endtask

    // One sweep from the current channel; abort_k >= 0 drops enable at window sample abort_j.
    task automatic apply_stimulus(input int wl, input int abort_k, input int abort_j);
        int le;
        int per;
        int sc;
        int nch;
        int stop_r;
        int sd;
        int ndone;
        le     = (wl == 0) ? 1 : wl;
        per    = le + 3;
        sc     = exp_cur;
        nch    = N_CH - sc;
        stop_r = (abort_k >= 0) ? 2 + abort_k * per + abort_j : nch * per;
        sd     = 0;
        bus.enable = 1'b0;
        @(posedge clk); #1;
        for (int r = 0; r <= stop_r; r++) begin
            bus.enable     = (r < stop_r);
            bus.pulse_in   = stim[r];
            bus.window_len = ((r % per) == 1) ? WIN_BITS'(wl) : WIN_BITS'($urandom);
            @(posedge clk); #1;
            if (bus.sweep_done) sd++;
        end
        ndone = (abort_k >= 0) ? abort_k : nch;
        for (int i = 0; i < ndone; i++) model_window(sc + i, 2 + i * per, le);
        exp_cur = (abort_k >= 0) ? sc + abort_k : 0;
        check_output("sweep_done strobes", sd, (abort_k >= 0) ? 0 : 1);
        check_output("cur_ch after sweep", int'(bus.cur_ch), exp_cur);
        check_output("busy after sweep", int'(bus.busy), 0);
        check_bank($sformatf("sweep wl=%0d", wl));
    endtask

    initial begin
        int wl;
        int per;

        vecs[0] = '{0, 0, 12,  5,  1'b1};
        vecs[1] = '{0, 1,  3,  3,  1'b1};
        vecs[2] = '{0, 2,  1,  1,  1'b1};
        vecs[3] = '{0, 3,  0,  SAT, 1'b0};
        vecs[4] = '{1, 0, 12,  5,  1'b1};
        vecs[5] = '{1, 1,  3,  3,  1'b1};
        vecs[6] = '{1, 2, SAT, SAT, 1'b1};
        vecs[7] = '{1, 3,  0,  SAT, 1'b0};

        reset_n        = 1'b0;
        bus.enable     = 1'b0;
        bus.window_len = '0;
        bus.pulse_in   = '0;
        bus.rd_ch      = '0;
        model_reset();
        #12;
        check_output("reset cur_ch", int'(bus.cur_ch), 0);
        check_output("reset busy", int'(bus.busy), 0);
        check_output("reset sweep_done", int'(bus.sweep_done), 0);
        check_bank("reset");
        @(negedge clk) reset_n = 1'b1;

        // ch0 pulses 5/12/7, ch1 starts high (discarded) then 3, ch2 single-cycle, ch3 idle.
        clear_stim();
        set_hi(0, 0, 103, 10, 5);
        set_hi(0, 0, 103, 25, 12);
        set_hi(0, 0, 103, 47, 7);
        set_hi(1, 1, 103, 0, 20);
        set_hi(1, 1, 103, 30, 3);
        set_hi(2, 2, 103, 50, 1);
        apply_stimulus(100, -1, 0);
        check_table(0);

        // Long pulse saturates; channels without pulses keep their earlier results.
        clear_stim();
        set_hi(2, 2, 403, 5, 300);
        apply_stimulus(400, -1, 0);
        check_table(1);

        // Abort during ch1 MEASURE after a completed pulse: bank[1] must not change.
        clear_stim();
        set_hi(1, 1, 53, 5, 4);
        apply_stimulus(50, 1, 20);

        fill_random(3 * 23 + 4);
        apply_stimulus(20, -1, 0);

        for (int it = 0; it < 6; it++) begin
            wl  = (it == 0) ? 0 : int'($urandom_range(1, 30));
            per = ((wl == 0) ? 1 : wl) + 3;
            fill_random(N_CH * per + 4);
            apply_stimulus(wl, -1, 0);
        end

        // Asynchronous reset in the middle of the second channel's window.
        fill_random(64);
        bus.enable = 1'b0;
        @(posedge clk); #1;
        bus.window_len = WIN_BITS'(20);
        for (int r = 0; r < 30; r++) begin
            bus.enable   = 1'b1;
            bus.pulse_in = stim[r];
            @(posedge clk); #1;
        end
        check_output("pre-reset busy", int'(bus.busy), 1);
        check_output("pre-reset cur_ch", int'(bus.cur_ch), 1);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_output("async reset cur_ch", int'(bus.cur_ch), 0);
        check_output("async reset busy", int'(bus.busy), 0);
        check_output("async reset sweep_done", int'(bus.sweep_done), 0);
        check_bank("async reset");
        bus.enable = 1'b0;
        @(negedge clk) reset_n = 1'b1;

        fill_random(N_CH * 15 + 4);
        apply_stimulus(12, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
